// File: rtl/tdm_arbiter.sv
// tdm_arbiter: time-division arbiter sharing one resource between an L and an H domain.
// Latency: 0 cycles; grant and res_* are combinational from the registered slot state.
// Backpressure: res_ready only qualifies the owning domain's grant and never stretches a slot.
module tdm_arbiter #(
  parameter int unsigned SLOT_LEN = 10,
  parameter int unsigned GUARD    = 1,
  parameter int unsigned W        = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_l,
  input  logic [W-1:0] data_l,
  input  logic         req_h,
  input  logic [W-1:0] data_h,
  input  logic         res_ready,
  output logic         res_valid,
  output logic [W-1:0] res_data,
  output logic         gnt_l,
  output logic         gnt_h,
  output logic         mode,
  output logic [15:0]  timer
);

  // Phase encoding. The register holding it is L-labelled: its next value
  // is computed from itself and the timer only.
  localparam logic [1:0] L_SLOT   = 2'd0;
  localparam logic [1:0] GUARD_LH = 2'd1;
  localparam logic [1:0] H_SLOT   = 2'd2;
  localparam logic [1:0] GUARD_HL = 2'd3;

  // Reload values for the phase timer (counts remaining cycles down to 0).
  // GUARD_LOAD is never used when GUARD is 0; it is forced to 0 to keep it tidy.
  localparam logic [15:0] SLOT_LOAD  = 16'(SLOT_LEN - 1);
  localparam logic [15:0] GUARD_LOAD = (GUARD == 0) ? 16'd0 : 16'(GUARD - 1);
  localparam bit          NO_GUARD   = (GUARD == 0);

  logic [1:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        phase_end;
  logic        own_l;
  logic        own_h;

  assign phase_end = (timer_q == 16'd0);

  // Phase sequencer: a pure function of state and timer so that nothing the
  // H domain drives (req_h, data_h, res_ready) can modulate the schedule.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (!phase_end) begin
      // Plain countdown; the zero case is handled below so it cannot wrap.
      timer_d = timer_q - 16'd1;
    end else begin
      case (state_q)
        L_SLOT: begin
          if (NO_GUARD) begin
            state_d = H_SLOT;
            timer_d = SLOT_LOAD;
          end else begin
            state_d = GUARD_LH;
            timer_d = GUARD_LOAD;
          end
        end
        GUARD_LH: begin
          state_d = H_SLOT;
          timer_d = SLOT_LOAD;
        end
        H_SLOT: begin
          if (NO_GUARD) begin
            state_d = L_SLOT;
            timer_d = SLOT_LOAD;
          end else begin
            state_d = GUARD_HL;
            timer_d = GUARD_LOAD;
          end
        end
        GUARD_HL: begin
          state_d = L_SLOT;
          timer_d = SLOT_LOAD;
        end
        default: begin
          state_d = L_SLOT;
          timer_d = SLOT_LOAD;
        end
      endcase
    end
  end

  // Phase registers; reset parks the schedule at the top of an L slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= L_SLOT;
      timer_q <= SLOT_LOAD;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Ownership of the resource this cycle. rst_n gates it directly so the
  // outputs go quiet the instant reset asserts, whatever the requesters do.
  assign own_l = rst_n && (state_q == L_SLOT);
  assign own_h = rst_n && (state_q == H_SLOT);

  // Output mux: only the owning domain's request/payload reaches the
  // resource; guard phases present nothing so in-flight beats drain.
  always_comb begin
    res_valid = 1'b0;
    res_data  = '0;
    gnt_l     = 1'b0;
    gnt_h     = 1'b0;
    if (own_l) begin
      res_valid = req_l;
      res_data  = req_l ? data_l : '0;
      gnt_l     = req_l & res_ready;
    end else if (own_h) begin
      res_valid = req_h;
      res_data  = req_h ? data_h : '0;
      gnt_h     = req_h & res_ready;
    end
  end

  // Domain indicator: the guard after a slot still belongs to that slot's side.
  assign mode  = (state_q == H_SLOT) || (state_q == GUARD_HL);
  assign timer = timer_q;

endmodule

// File: tb/tb_tdm_arbiter.sv
// tb_tdm_arbiter: three arbiters (10/1 with live H, 10/1 with silent H, 1/0) driven
// from one stimulus stream and checked each cycle against a position-in-period model,
// plus literal expectations at known points of the schedule.
module tb_tdm_arbiter;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         req_l, req_h, res_ready;
  logic [W-1:0] data_l, data_h;

  logic         a_vld, a_gl, a_gh, a_mode;
  logic [W-1:0] a_dat;
  logic [15:0]  a_tmr;
  logic         b_vld, b_gl, b_gh, b_mode;
  logic [W-1:0] b_dat;
  logic [15:0]  b_tmr;
  logic         c_vld, c_gl, c_gh, c_mode;
  logic [W-1:0] c_dat;
  logic [15:0]  c_tmr;

  tdm_arbiter #(.SLOT_LEN(10), .GUARD(1), .W(W)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_l(req_l), .data_l(data_l),
    .req_h(req_h), .data_h(data_h), .res_ready(res_ready),
    .res_valid(a_vld), .res_data(a_dat), .gnt_l(a_gl), .gnt_h(a_gh),
    .mode(a_mode), .timer(a_tmr)
  );

  tdm_arbiter #(.SLOT_LEN(10), .GUARD(1), .W(W)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_l(req_l), .data_l(data_l),
    .req_h(1'b0), .data_h(data_h), .res_ready(res_ready),
    .res_valid(b_vld), .res_data(b_dat), .gnt_l(b_gl), .gnt_h(b_gh),
    .mode(b_mode), .timer(b_tmr)
  );

  tdm_arbiter #(.SLOT_LEN(1), .GUARD(0), .W(W)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_l(req_l), .data_l(data_l),
    .req_h(req_h), .data_h(data_h), .res_ready(res_ready),
    .res_valid(c_vld), .res_data(c_dat), .gnt_l(c_gl), .gnt_h(c_gh),
    .mode(c_mode), .timer(c_tmr)
  );

  int n;            // posedges since reset release
  int vectors;
  int miscompares;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (n=%0d t=%0t)", nm, act, exp, n, $time);
    end
  endtask

  // Reference: place the cycle within a period of L slot, guard, H slot, guard.
  task automatic check_dut(input string nm, input int s, input int g, input logic rh,
                           input logic vld, input logic [W-1:0] dat, input logic gl,
                           input logic gh, input logic md, input logic [15:0] tmr);
    int per, pos, ph, t;
    logic e_v, e_gl, e_gh, e_m;
    logic [W-1:0] e_d;
    per = 2 * (s + g);
    pos = n % per;
    if (pos < s) begin
      ph = 0; t = s - 1 - pos;
    end else if (pos < s + g) begin
      ph = 1; t = s + g - 1 - pos;
    end else if (pos < 2 * s + g) begin
      ph = 2; t = 2 * s + g - 1 - pos;
    end else begin
      ph = 3; t = per - 1 - pos;
    end
    e_m = (ph >= 2);
    e_v = 1'b0; e_d = '0; e_gl = 1'b0; e_gh = 1'b0;
    if (rst_n && ph == 0) begin
      e_v = req_l; e_d = req_l ? data_l : '0; e_gl = req_l & res_ready;
    end else if (rst_n && ph == 2) begin
      e_v = rh; e_d = rh ? data_h : '0; e_gh = rh & res_ready;
    end
    check({nm, ".mode"}, 32'(md), 32'(e_m));
    check({nm, ".timer"}, 32'(tmr), 32'(16'(t)));
    check({nm, ".res_valid"}, 32'(vld), 32'(e_v));
    check({nm, ".res_data"}, 32'(dat), 32'(e_d));
    check({nm, ".gnt_l"}, 32'(gl), 32'(e_gl));
    check({nm, ".gnt_h"}, 32'(gh), 32'(e_gh));
  endtask

  task automatic check_all();
    check_dut("a", 10, 1, req_h, a_vld, a_dat, a_gl, a_gh, a_mode, a_tmr);
    check_dut("b", 10, 1, 1'b0,  b_vld, b_dat, b_gl, b_gh, b_mode, b_tmr);
    check_dut("c", 1,  0, req_h, c_vld, c_dat, c_gl, c_gh, c_mode, c_tmr);
    check("c.gnt_exclusive", 32'(c_gl & c_gh), 32'd0);
  endtask

  // One cycle: edge, update the model's cycle count, drive, sample at negedge.
  task automatic step(input logic rst_v, input logic rl, input logic rh, input logic rdy,
                      input logic [W-1:0] dl, input logic [W-1:0] dh);
    @(posedge clk);
    if (rst_n) n++;
    #1;
    rst_n = rst_v; req_l = rl; req_h = rh; res_ready = rdy; data_l = dl; data_h = dh;
    if (!rst_n) n = 0;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    vectors = 0; miscompares = 0; n = 0;
    rst_n = 1'b0; req_l = 1'b1; req_h = 1'b1; res_ready = 1'b1;
    data_l = 16'h1234; data_h = 16'h4321;

    // Reset held with live requests: outputs stay quiet, timer parked.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h4321);
    check("rst.a_res_valid", 32'(a_vld), 32'd0);
    check("rst.a_timer", 32'(a_tmr), 32'd9);
    check("rst.a_gnt_l", 32'(a_gl), 32'd0);

    // Release with L streaming 0x00AA; H raises its request on the last L cycle.
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h00AA, 16'h5555);
    check("rel.a_timer", 32'(a_tmr), 32'd9);
    check("rel.a_gnt_l", 32'(a_gl), 32'd1);
    for (int k = 1; k <= 38; k++) begin
      step(1'b1, 1'b1, (k >= 9), 1'b1, 16'h00AA, 16'h5555);
      if (k == 1) check("c.mode_n1", 32'(c_mode), 32'd1);
      if (k == 2) check("c.mode_n2", 32'(c_mode), 32'd0);
      if (k == 9) begin
        check("n9.a_timer", 32'(a_tmr), 32'd0);
        check("n9.a_gnt_h", 32'(a_gh), 32'd0);
        check("n9.a_res_data", 32'(a_dat), 32'h00AA);
      end
      if (k == 10) begin
        check("n10.a_mode", 32'(a_mode), 32'd0);
        check("n10.a_gnt_h", 32'(a_gh), 32'd0);
        check("n10.a_res_data", 32'(a_dat), 32'd0);
      end
      if (k == 11) begin
        check("n11.a_mode", 32'(a_mode), 32'd1);
        check("n11.a_timer", 32'(a_tmr), 32'd9);
        check("n11.a_gnt_h", 32'(a_gh), 32'd1);
        check("n11.a_res_data", 32'(a_dat), 32'h5555);
      end
      if (k == 21) begin
        check("n21.a_mode", 32'(a_mode), 32'd1);
        check("n21.a_timer", 32'(a_tmr), 32'd0);
      end
      if (k == 22) begin
        check("n22.a_mode", 32'(a_mode), 32'd0);
        check("n22.a_timer", 32'(a_tmr), 32'd9);
        check("n22.a_gnt_l", 32'(a_gl), 32'd1);
      end
    end
    check("n38.a_timer", 32'(a_tmr), 32'd4);
    check("n38.a_gnt_h", 32'(a_gh), 32'd1);

    // Asynchronous reset in the middle of the H slot.
    #1;
    rst_n = 1'b0;
    n = 0;
    #1;
    check("arst.a_mode", 32'(a_mode), 32'd0);
    check("arst.a_gnt_h", 32'(a_gh), 32'd0);
    check("arst.a_res_valid", 32'(a_vld), 32'd0);
    check("arst.a_timer", 32'(a_tmr), 32'd9);
    check_all();
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'h00AA, 16'h5555);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h00AA, 16'h5555);
    check("rel2.a_timer", 32'(a_tmr), 32'd9);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h00AA, 16'h5555);
    check("rel2.a_timer_next", 32'(a_tmr), 32'd8);
    check("rel2.a_mode", 32'(a_mode), 32'd0);

    // Random traffic on both domains with occasional resets.
    for (int i = 0; i < 700; i++) begin
      step(($urandom_range(0, 149) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tdm_arbiter.md
TDM_ARBITER -- requirements
Module: tdm_arbiter

Interface
REQ-001 Parameter SLOT_LEN, default 10, sets the cycles per security slot; legal range 1..65535.
REQ-002 Parameter GUARD, default 1, sets the idle cycles between slots; legal range 0..255.
REQ-003 Parameter W, default 16, sets the data width.
REQ-004 Port clk, input, 1 bit, sole clock, label L; all state updates on its posedge.
REQ-005 Port rst_n, input, 1 bit, reset; asynchronous, active-low, label L.
REQ-006 Port req_l, input, 1 bit, L requester wants the shared resource, label L.
REQ-007 Port data_l, input, W bits, L request payload, label L.
REQ-008 Port req_h, input, 1 bit, H requester wants the shared resource, label H.
REQ-009 Port data_h, input, W bits, H request payload, label H.
REQ-010 Port res_ready, input, 1 bit, shared resource accepts the presented beat; label follows mode.
REQ-011 Port res_valid, output, 1 bit, beat presented to the resource; label follows mode.
REQ-012 Port res_data, output, W bits, payload to the resource; label follows mode.
REQ-013 Port gnt_l, output, 1 bit, L beat accepted this cycle, label L.
REQ-014 Port gnt_h, output, 1 bit, H beat accepted this cycle, label H.
REQ-015 Port mode, output, 1 bit, 0 = L domain, 1 = H domain, label L.
REQ-016 Port timer, output, 16 bits, remaining cycles in the current phase, label L.

Function
REQ-017 The block SHALL implement four states: L_SLOT, GUARD_LH, H_SLOT and GUARD_HL, encoded in a label-L register.
REQ-018 On each slot entry, timer SHALL load SLOT_LEN-1; it SHALL decrement by 1 per cycle and never wrap below 0.
REQ-019 At timer==0, L_SLOT SHALL go to GUARD_LH and H_SLOT SHALL go to GUARD_HL; if GUARD==0, each SHALL go directly to the opposite slot.
REQ-020 On guard entry, timer SHALL load GUARD-1; at timer==0, GUARD_LH SHALL go to H_SLOT and GUARD_HL SHALL go to L_SLOT.
REQ-021 State and timer transitions SHALL depend only on state and timer, never on req_h, data_h or res_ready; this is the non-interference rule.
REQ-022 In L_SLOT: res_valid = req_l, res_data = data_l, gnt_l = req_l & res_ready, gnt_h = 0.
REQ-023 In H_SLOT: res_valid = req_h, res_data = data_h, gnt_h = req_h & res_ready, gnt_l = 0.
REQ-024 In either guard state: res_valid = 0, res_data = 0, gnt_l = 0, gnt_h = 0, so the resource drains before the domain changes.
REQ-025 mode SHALL be 0 in L_SLOT and GUARD_LH, and 1 in H_SLOT and GUARD_HL.
REQ-026 Outputs SHALL be combinational from the registered state plus the current-domain inputs; grant latency SHALL be 0 cycles.
REQ-027 A request held across a slot end SHALL NOT be granted until that requester's next slot; the requester holds req and data stable.
REQ-028 Off-slot requests SHALL be ignored, with no queuing or counting inside the block.
REQ-029 res_data SHALL be exactly W bits, zero-filled when res_valid is 0.
REQ-030 Timer arithmetic SHALL be unsigned 16-bit.

Reset
REQ-031 While rst_n is 0, the block SHALL be in state L_SLOT with timer = SLOT_LEN-1, mode = 0 and all of gnt_l, gnt_h, res_valid and res_data = 0, regardless of the inputs.
REQ-032 Reset assertion mid-slot, including during H_SLOT, SHALL take effect immediately and asynchronously.
REQ-033 After rst_n deasserts, the first posedge SHALL begin L_SLOT counting, with timer decrementing from SLOT_LEN-1.

Verification
REQ-034 Scenario: SLOT_LEN=10, GUARD=1, no requests, reset released -> mode sequence is 0×11, then 1×11, then repeats; timer follows 9..0, then 0, then 9..0.
REQ-035 Scenario: req_l=1, res_ready=1 held, data_l=0x00AA -> gnt_l=1 and res_data=0x00AA for exactly the 10 L_SLOT cycles per period; 0 in the guard and H phases.
REQ-036 Scenario: req_h randomly toggled with data_h random versus req_h=0 throughout, under an identical L stimulus -> mode, timer, gnt_l and L-phase res_data are cycle-identical in both runs.
REQ-037 Scenario: req_h=1 rises at the last L_SLOT cycle (timer==0) -> gnt_h stays 0 through GUARD_LH; gnt_h=1 on the first H_SLOT cycle.
REQ-038 Scenario: rst_n pulled low at H_SLOT timer==4 -> mode=0, gnt_h=0, res_valid=0 in the same cycle; after release, timer restarts at 9 in L_SLOT.
REQ-039 Scenario: GUARD=0, SLOT_LEN=1 -> mode toggles every cycle, and gnt_l and gnt_h are never both 1.
